// File: rtl/hls_cnn_2d_100s_mac_pkg.sv
// Shared constants and parameter checks for the CNN MAC pipe.
// Saturation bounds, rounding offset and legal-range predicates.
package hls_cnn_2d_100s_mac_pkg;

    localparam int MIN_STAGE = 1;
    localparam int MAX_STAGE = 4;

    function automatic longint SMAX(input int w);
        return (longint'(1) <<< (w - 1)) - longint'(1);
    endfunction

    function automatic longint SMIN(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

    function automatic longint RND(input int shift);
        return longint'(1) <<< (shift - 1);
    endfunction

    function automatic bit STAGE_OK(input int n);
        return (n >= MIN_STAGE) && (n <= MAX_STAGE);
    endfunction

    function automatic bit SHIFT_OK(input int s, input int accw);
        return (s >= 1) && (s <= accw - 2);
    endfunction

endpackage

// File: rtl/hls_cnn_2d_100s_mac_pipe_reg.sv
// Width-parametrised pipeline register.
// Holds on ce low, clears on async reset.
module hls_cnn_2d_100s_mac_pipe_reg #(
    parameter int W = 1
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_ce,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    // one delay stage of the {valid, last, product} bundle
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_q <= '0;
        end else if (i_ce) begin
            o_q <= i_d;
        end
    end

endmodule

// File: rtl/hls_cnn_2d_100s_mac_pipe.sv
// Pipelined signed MAC with frame accumulation,
// round-half-up shift and saturation of the frame result.
module hls_cnn_2d_100s_mac_pipe
    import hls_cnn_2d_100s_mac_pkg::*;
#(
    parameter int ID         = 1,
    parameter int NUM_STAGE  = 2,
    parameter int din0_WIDTH = 16,
    parameter int din1_WIDTH = 15,
    parameter int ACC_WIDTH  = 40,
    parameter int FRAC_SHIFT = 10,
    parameter int dout_WIDTH = 16
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst,
    input  logic                         ce,
    input  logic                         in_valid,
    input  logic                         in_last,
    input  logic signed [din0_WIDTH-1:0] din0,
    input  logic signed [din1_WIDTH-1:0] din1,
    output logic                         out_valid,
    output logic signed [dout_WIDTH-1:0] dout,
    output logic signed [ACC_WIDTH-1:0]  acc_dout,
    output logic                         ovf
);

    localparam int PW = din0_WIDTH + din1_WIDTH;
    localparam int SW = ACC_WIDTH + 2;

    localparam logic signed [ACC_WIDTH:0] L_MAX =
        (ACC_WIDTH + 1)'(SMAX(dout_WIDTH));
    localparam logic signed [ACC_WIDTH:0] L_MIN =
        (ACC_WIDTH + 1)'(SMIN(dout_WIDTH));
    localparam logic signed [ACC_WIDTH:0] L_RND =
        (ACC_WIDTH + 1)'(RND(FRAC_SHIFT));

    if (!STAGE_OK(NUM_STAGE)) begin : g_bad_stage
        $error("NUM_STAGE must be in 1..4");
    end
    if (!SHIFT_OK(FRAC_SHIFT, ACC_WIDTH)) begin : g_bad_shift
        $error("FRAC_SHIFT must be in 1..ACC_WIDTH-2");
    end
    if (ACC_WIDTH < PW) begin : g_bad_acc
        $error("ACC_WIDTH narrower than the product");
    end
    if (ID < 0) begin : g_bad_id
        $error("ID must be non-negative");
    end

    logic signed [PW-1:0]        w_prod_full;
    logic signed [ACC_WIDTH-1:0] w_prod_ext;
    logic [SW-1:0]               w_stage [0:NUM_STAGE];
    logic                        w_pv;
    logic                        w_pl;
    logic signed [ACC_WIDTH-1:0] w_pp;
    logic signed [ACC_WIDTH:0]   w_acc_x;
    logic signed [ACC_WIDTH:0]   w_rnd_sum;
    logic signed [ACC_WIDTH:0]   w_r;

    logic                        r_first;
    logic                        r_done;
    logic signed [ACC_WIDTH-1:0] r_acc;

    assign w_prod_full = din0 * din1;
    assign w_prod_ext  = ACC_WIDTH'(w_prod_full);
    assign w_stage[0]  = {in_valid, in_valid & in_last, w_prod_ext};

    for (genvar g = 0; g < NUM_STAGE; g++) begin : g_pipe
        hls_cnn_2d_100s_mac_pipe_reg #(
            .W(SW)
        ) u_reg (
            .i_clk(ap_clk),
            .i_rst(ap_rst),
            .i_ce (ce),
            .i_d  (w_stage[g]),
            .o_q  (w_stage[g+1])
        );
    end

    assign w_pv = w_stage[NUM_STAGE][SW-1];
    assign w_pl = w_stage[NUM_STAGE][SW-2];
    assign w_pp = $signed(w_stage[NUM_STAGE][ACC_WIDTH-1:0]);

    // frame accumulator; a last beat re-arms first for the next frame
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_acc   <= '0;
            r_first <= 1'b1;
            r_done  <= 1'b0;
        end else if (ce) begin
            r_done <= w_pv & w_pl;
            if (w_pv) begin
                r_acc   <= r_first ? w_pp : r_acc + w_pp;
                r_first <= w_pl;
            end
        end
    end

    // one guard bit so the rounding offset never overflows
    always_comb begin
        w_acc_x   = {r_acc[ACC_WIDTH-1], r_acc};
        w_rnd_sum = w_acc_x + L_RND;
        w_r       = w_rnd_sum >>> FRAC_SHIFT;
    end

    // register the finished frame with saturation to dout range
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            out_valid <= 1'b0;
            dout      <= '0;
            acc_dout  <= '0;
            ovf       <= 1'b0;
        end else if (ce) begin
            out_valid <= r_done;
            if (r_done) begin
                acc_dout <= r_acc;
                if (w_r > L_MAX) begin
                    dout <= L_MAX[dout_WIDTH-1:0];
                    ovf  <= 1'b1;
                end else if (w_r < L_MIN) begin
                    dout <= L_MIN[dout_WIDTH-1:0];
                    ovf  <= 1'b1;
                end else begin
                    dout <= w_r[dout_WIDTH-1:0];
                    ovf  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/hls_cnn_2d_100s_mac_pipe.md
# hls_cnn_2d_100s_mac_pipe

Parametrised, pipelined signed multiply-accumulate unit that succeeds the single-cycle combinational `mul_16s_15s` primitive used in the CNN datapath. It registers the product through a configurable number of stages and accumulates a stream of products framed by a `last` flag. At the end of each frame it emits a rounded, saturated fixed-point result. It sits between the line-buffer/weight fetch logic and the activation stage of each convolution channel.

## Interface
Parameters:
- `ID`, 1, instance tag; no functional effect.
- `NUM_STAGE`, 2, product pipeline depth, legal range 1..4.
- `din0_WIDTH`, 16, signed activation width.
- `din1_WIDTH`, 15, signed weight width.
- `ACC_WIDTH`, 40, signed accumulator width; must be ≥ `din0_WIDTH + din1_WIDTH`.
- `FRAC_SHIFT`, 10, right shift applied to the accumulator before output; legal range 1..`ACC_WIDTH-2`.
- `dout_WIDTH`, 16, signed result width.

Ports:
- `ap_clk`, in, 1, sole clock; all logic is on the rising edge.
- `ap_rst`, in, 1, asynchronous, active-high reset.
- `ce`, in, 1, clock enable; when low, all state holds.
- `in_valid`, in, 1, `din0`/`din1` carry a valid pair this cycle.
- `in_last`, in, 1, marks the final pair of a frame; meaningful only with `in_valid`.
- `din0`, in, `din0_WIDTH`, signed activation.
- `din1`, in, `din1_WIDTH`, signed weight.
- `out_valid`, out, 1, one-cycle pulse carrying a frame result.
- `dout`, out, `dout_WIDTH`, rounded and saturated result.
- `acc_dout`, out, `ACC_WIDTH`, raw accumulator value of the finished frame.
- `ovf`, out, 1, saturation occurred on this result; qualified by `out_valid`.

## Operation
- Stage 1 registers `$signed(din0)*$signed(din1)`, sign-extended to `ACC_WIDTH`, together with its `valid` and `last` bits. Stages 2..`NUM_STAGE` are plain delay registers for the {product, valid, last} triple.
- Accumulator stage: when a valid product leaves the pipe:
  - If the `first` flag is set, `acc` ← product. Otherwise `acc` ← `acc` + product, using two's-complement wrap at `ACC_WIDTH` (no internal saturation).
  - `first` is set by reset and by the `last` beat. It clears after any non-last valid beat.
- Output stage: on the cycle after a `last` beat updates `acc`:
  - `out_valid` is 1 and `acc_dout` shows the final `acc`.
  - `r` = (`acc` + 2^(`FRAC_SHIFT`-1)) >>> `FRAC_SHIFT`, computed as an arithmetic shift in `ACC_WIDTH`+1 bits (round half toward +inf).
  - If `r` exceeds the signed `dout_WIDTH` maximum, `dout` = max and `ovf` = 1. If `r` is below the minimum, `dout` = min and `ovf` = 1. Otherwise `dout` = `r` and `ovf` = 0.
- A single-beat frame (`in_valid` and `in_last` together on a fresh frame) outputs that one product's result.
- Invalid beats are bubbles: they are neither accumulated nor do they change `first`.
- Back-to-back frames are supported with no dead cycle. A `last` beat followed immediately by the next frame's first beat starts a fresh accumulation.

## Timing
- Reset values: all pipe valid bits 0, `first` = 1, `acc` = 0, `out_valid` = 0, `dout` = 0, `acc_dout` = 0, `ovf` = 0.
- Latency: a `last` beat accepted at edge t (with `ce` = 1) produces `out_valid` = 1 after edge t + `NUM_STAGE` + 1, counting only edges where `ce` = 1.
- Throughput: one pair per enabled cycle. There is no backpressure; the consumer must accept every `out_valid` pulse.
- `ce` = 0 freezes every register, including `out_valid`. A pulse held this way stays asserted until the next enabled edge, after which it drops unless a new result arrives.
- If `ap_rst` asserts mid-frame, the partial sum and all in-flight beats are discarded. No `out_valid` is emitted for that frame; the first beat after reset release starts a new frame.
- `in_last` without `in_valid` is ignored.

## Structure
- Shared package `hls_cnn_2d_100s_mac_pkg` holds:
  - the saturation bound constants as functions of width (`SMAX(w)`, `SMIN(w)`);
  - the rounding constant `RND(shift)`;
  - the legal-range checks for `NUM_STAGE` and `FRAC_SHIFT`, which fire as elaboration errors.
- One sub-module: `hls_cnn_2d_100s_mac_pipe_reg`, a parametrised-width register with `ce` and async reset. It is instantiated `NUM_STAGE` times in a generate loop.
- Rounding, saturation and the accumulator stay in the top module.

## Test plan
- **Single beat:** `NUM_STAGE` = 2, `FRAC_SHIFT` = 10; reset, then `din0` = 1024, `din1` = 3, `in_valid` = `in_last` = 1. Required: `out_valid` 3 cycles later, `acc_dout` = 3072, `dout` = 3, `ovf` = 0.
- **Rounding:** a 3-beat frame whose products are 512, 512 and −1, giving `acc` = 1023. Required: `dout` = 1 (rounds up). A second frame with `acc` = −513 gives `dout` = −1.
- **Saturation:** a 4-beat frame of `din0` = 32767, `din1` = 16383. Required: `ovf` = 1, `dout` = 32767. The same frame with `din0` = −32768 gives `dout` = −32768, `ovf` = 1.
- **Back-to-back with bubbles:**
  - Stimulus: frame A = {2×2, 3×3 last} sent with `FRAC_SHIFT` = 1, one invalid beat inserted mid-frame; frame B = {5×5 last} sent the very next cycle.
  - Required: two `out_valid` pulses carrying `acc_dout` = 13 and 25, with no carry-over between frames.
- **`ce` stall:** hold `ce` = 0 for 5 cycles while a `last` beat is in flight. Required: `out_valid` is delayed by exactly 5 cycles and `dout` is unchanged.
- **Reset mid-frame:** pulse `ap_rst` after 2 of 4 beats, then send a 1-beat frame of 7×1. Required: the only output is `acc_dout` = 7, and all outputs are 0 during reset.
